// File: rtl/pc_pkg.sv
// Shared constants and types for the fetch-stage next-PC logic.
package pc_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  // Link registers recognised for call/return tracking (ra, t0).
  localparam int unsigned LINK_REG_RA = 1;
  localparam int unsigned LINK_REG_T0 = 5;

  typedef enum logic [1:0] {
    CT_NONE,
    CT_JAL,
    CT_JALR,
    CT_BRANCH
  } ctrl_kind_t;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: overflow overwrites the oldest entry, empty pops are dropped.
// Push and pop together replace the top entry without changing the count.
module return_addr_stack #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] push_data,
  output logic [Width-1:0] top,
  output logic             valid
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  tp_q;
  logic [PtrW-1:0]  tp_inc;
  logic [CntW-1:0]  cnt_q;
  logic             pop_eff;

  assign pop_eff = pop && (cnt_q != '0);
  assign tp_inc  = tp_q + PtrW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      tp_q  <= '0;
      cnt_q <= '0;
    end else if (push && pop_eff) begin
      mem_q[tp_q] <= push_data;
    end else if (push) begin
      tp_q          <= tp_inc;
      mem_q[tp_inc] <= push_data;
      if (cnt_q != CntW'(Depth)) cnt_q <= cnt_q + CntW'(1);
    end else if (pop_eff) begin
      tp_q  <= tp_q - PtrW'(1);
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign valid = (cnt_q != '0);
  assign top   = valid ? mem_q[tp_q] : '0;

endmodule

// File: rtl/next_pc_unit.sv
// Fetch PC generator: sequential +4, EX-stage redirect with flush, misaligned-target flag.
// Optional return-address stack enabled by defining RAS_EN.
module next_pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned          PC_WIDTH  = 64,
  parameter int unsigned          REG_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
  parameter int unsigned          RAS_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 ex_valid,
  input  logic [PC_WIDTH-1:0]  ex_pc,
  input  logic [REG_WIDTH-1:0] imm,
  input  logic [REG_WIDTH-1:0] rs1,
  input  logic                 is_jal,
  input  logic                 is_jalr,
  input  logic                 is_branch,
  input  logic                 branch_taken,
  input  logic                 rd_is_link,
  input  logic                 rs1_is_link,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 flush,
  output logic                 misaligned,
  output logic [PC_WIDTH-1:0]  ras_top,
  output logic                 ras_valid
);

  ctrl_kind_t           kind;
  logic [REG_WIDTH-1:0] rel_sum;
  logic [REG_WIDTH-1:0] jalr_sum;
  logic [PC_WIDTH-1:0]  target;
  logic [PC_WIDTH-1:0]  pc_q;
  logic [PC_WIDTH-1:0]  pc_d;
  logic                 take;
  logic                 bad;
  logic                 redirect;

  always_comb begin
    kind = CT_NONE;
    if (ex_valid) begin
      if (is_jal)                          kind = CT_JAL;
      else if (is_jalr)                    kind = CT_JALR;
      else if (is_branch && branch_taken)  kind = CT_BRANCH;
    end
  end

  assign rel_sum  = REG_WIDTH'(ex_pc) + imm;
  assign jalr_sum = (rs1 + imm) & ~REG_WIDTH'(1);

  always_comb begin
    target = rel_sum[PC_WIDTH-1:0];
    if (kind == CT_JALR) target = jalr_sum[PC_WIDTH-1:0];
  end

  assign take       = (kind != CT_NONE);
  assign bad        = take && target[1];
  assign redirect   = take && !bad;
  assign flush      = redirect;
  assign misaligned = bad;

  // Redirect outranks stall; reset outranks both in the register below.
  always_comb begin
    pc_d = pc_q + PC_WIDTH'(INSTR_BYTES);
    if (redirect)   pc_d = target;
    else if (stall) pc_d = pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc = pc_q;

`ifdef RAS_EN
  logic ras_ok;
  logic ras_push;
  logic ras_pop;

  // A misaligned transfer traps, so it must not disturb call/return tracking.
  assign ras_ok   = ex_valid && !bad;
  assign ras_push = ras_ok && (is_jal || is_jalr) && rd_is_link;
  assign ras_pop  = ras_ok && is_jalr && rs1_is_link;

  return_addr_stack #(
    .Depth (RAS_DEPTH),
    .Width (PC_WIDTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (ex_pc + PC_WIDTH'(INSTR_BYTES)),
    .top       (ras_top),
    .valid     (ras_valid)
  );
`else
  logic unused_ras;
  assign unused_ras = ^{rd_is_link, rs1_is_link, 1'(RAS_DEPTH)};
  assign ras_top    = '0;
  assign ras_valid  = 1'b0;
`endif

endmodule
